// File: rtl/wb_pkg.sv
// Shared definitions for the write-back select pipeline: source codes and constants.
package wb_pkg;

  // Source select codes (MemToReg encoding).
  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_LOAD  = 3'd1,
    WB_SHIFT = 3'd2,
    WB_SLT   = 3'd3,
    WB_HI    = 3'd4,
    WB_LO    = 3'd5,
    WB_C227  = 3'd6,
    WB_RSVD  = 3'd7
  } wb_sel_e;

  // Constant source presented on code WB_C227.
  localparam logic [31:0] C227 = 32'd227;

  // Default register-file address width.
  localparam int unsigned DEFAULT_REG_AW = 5;

endpackage

// File: rtl/wb_select_pipe_if.sv
// Request/response bus of the write-back select pipeline.
interface wb_select_pipe_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC),
  parameter int unsigned REG_AW  = 5
);
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_en;
  logic [SEL_W-1:0]         sel;
  logic [REG_AW-1:0]        in_dest;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_data;
  logic [REG_AW-1:0]        out_dest;
  logic                     out_we;
  logic                     out_valid;
  logic                     out_ready;

  // Producer / register-file side.
  modport master (
    output src_data, src_en, sel, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_dest, out_we, out_valid
  );

  // Pipeline stage side.
  modport slave (
    input  src_data, src_en, sel, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_dest, out_we, out_valid
  );
endinterface

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready buffer. Head entry drives the outputs directly;
// in_ready depends only on registered occupancy (and reset).
module wb_skid_buffer #(
  parameter int unsigned PW = 38
) (
  input  logic          clk_i,
  input  logic          rst_ni,      // synchronous, active-low
  input  logic [PW-1:0] in_payload_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [PW-1:0] out_payload_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [1:0]    occupancy_o
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [1:0]    occ_q, occ_d;
  logic          push, pop;

  assign in_ready_o    = rst_ni && (occ_q != 2'd2);
  assign out_valid_o   = (occ_q != 2'd0);
  assign out_payload_o = head_q;
  assign occupancy_o   = occ_q;

  // Next-state for the two slots; the tail only ever feeds the head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    push   = in_valid_i && in_ready_o;
    pop    = out_valid_o && out_ready_i;
    unique case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = in_payload_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_payload_i;
        end else if (push) begin
          tail_d = in_payload_i;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  // Slot and occupancy registers; reset discards all contents.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Write-back source selector with select checking, $zero write suppression,
// sticky illegal-select flag and a 2-entry output buffer.
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC),
  parameter int unsigned REG_AW  = DEFAULT_REG_AW
) (
  input  logic                clk,
  input  logic                reset,     // synchronous, active-low
  wb_select_pipe_if.slave     bus,
  output logic                err,
  input  logic                err_clr,
  output logic [1:0]          occupancy
);

  localparam int unsigned PW = 1 + REG_AW + WIDTH;

  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic [WIDTH-1:0] pay_data;
  logic             pay_we;
  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;
  logic             push;
  logic             err_q, err_d;

  // Mux the selected source; codes beyond NUM_SRC never match and stay illegal.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_ok   = bus.src_en[k];
        sel_data = bus.src_data[k*WIDTH +: WIDTH];
      end
    end
    pay_data   = sel_ok ? sel_data : '0;
    pay_we     = sel_ok && (bus.in_dest != '0);
    in_payload = {pay_we, bus.in_dest, pay_data};
  end

  assign push = bus.in_valid && bus.in_ready;

  // Sticky error: a new illegal accept wins over a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (push && !sel_ok) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  wb_skid_buffer #(
    .PW (PW)
  ) u_buf (
    .clk_i         (clk),
    .rst_ni        (reset),
    .in_payload_i  (in_payload),
    .in_valid_i    (bus.in_valid),
    .in_ready_o    (bus.in_ready),
    .out_payload_o (out_payload),
    .out_valid_o   (bus.out_valid),
    .out_ready_i   (bus.out_ready),
    .occupancy_o   (occupancy)
  );

  assign {bus.out_we, bus.out_dest, bus.out_data} = out_payload;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Self-checking bench for wb_select_pipe: scoreboard of expected entries plus
// a vector table and hand-written flow-control / error / reset sequences.
module tb_wb_select_pipe;
  import wb_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        we;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  dest;
    logic [7:0]  en;
    logic [31:0] data;
    logic        we;
    logic        err;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       err;
  logic       err_clr;
  logic [1:0] occupancy;

  int total = 0;
  int bad   = 0;

  exp_t        sb[$];
  logic [31:0] srcv[8];
  vec_t        vt[11];

  wb_select_pipe_if #(.WIDTH(32), .NUM_SRC(8), .SEL_W(3), .REG_AW(5)) bus ();

  wb_select_pipe #(
    .WIDTH   (32),
    .NUM_SRC (8),
    .SEL_W   (3),
    .REG_AW  (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err       (err),
    .err_clr   (err_clr),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(logic [2:0] s, logic [4:0] d, logic [7:0] en);
    exp_t e;
    e.dest = d;
    if (en[s]) begin
      e.data = srcv[s];
      e.we   = (d != 5'd0);
    end else begin
      e.data = 32'd0;
      e.we   = 1'b0;
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] s, input logic [4:0] d, input logic [7:0] en,
                      input exp_t e);
    int n;
    for (int k = 0; k < 8; k++) bus.src_data[k*32 +: 32] = srcv[k];
    bus.src_en   = en;
    bus.sel      = s;
    bus.in_dest  = d;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      sb.push_back(e);
    end
    #1;
    bus.in_valid = 1'b0;
    // Sources need not be held after acceptance.
    for (int k = 0; k < 8; k++) bus.src_data[k*32 +: 32] = $urandom;
  endtask

  // Scoreboard: compare the head whenever the DUT is about to pop it.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_dest", {27'd0, bus.out_dest}, {27'd0, e.dest});
        chk("out_we", {31'd0, bus.out_we}, {31'd0, e.we});
      end
    end
  end

  initial begin
    srcv[0] = 32'h0000_00AA;
    srcv[1] = 32'h1122_3344;
    srcv[2] = 32'h0F0F_0F0F;
    srcv[3] = 32'h0000_0001;
    srcv[4] = 32'hDEAD_BEEF;
    srcv[5] = 32'h1234_5678;
    srcv[6] = C227;
    srcv[7] = 32'hBAD0_BAD0;

    vt[0]  = '{sel: WB_ALU,   dest: 5'd8,  en: 8'h7F, data: 32'h0000_00AA, we: 1'b1, err: 1'b0};
    vt[1]  = '{sel: WB_LOAD,  dest: 5'd3,  en: 8'h7F, data: 32'h1122_3344, we: 1'b1, err: 1'b0};
    vt[2]  = '{sel: WB_SHIFT, dest: 5'd31, en: 8'h7F, data: 32'h0F0F_0F0F, we: 1'b1, err: 1'b0};
    vt[3]  = '{sel: WB_SLT,   dest: 5'd1,  en: 8'h7F, data: 32'h0000_0001, we: 1'b1, err: 1'b0};
    vt[4]  = '{sel: WB_HI,    dest: 5'd9,  en: 8'h7F, data: 32'hDEAD_BEEF, we: 1'b1, err: 1'b0};
    vt[5]  = '{sel: WB_LO,    dest: 5'd10, en: 8'h7F, data: 32'h1234_5678, we: 1'b1, err: 1'b0};
    vt[6]  = '{sel: WB_C227,  dest: 5'd0,  en: 8'h7F, data: 32'd227,       we: 1'b0, err: 1'b0};
    vt[7]  = '{sel: WB_RSVD,  dest: 5'd4,  en: 8'h7F, data: 32'd0,         we: 1'b0, err: 1'b1};
    vt[8]  = '{sel: WB_SHIFT, dest: 5'd0,  en: 8'h7F, data: 32'h0F0F_0F0F, we: 1'b0, err: 1'b0};
    vt[9]  = '{sel: WB_LOAD,  dest: 5'd7,  en: 8'h7D, data: 32'd0,         we: 1'b0, err: 1'b1};
    vt[10] = '{sel: WB_LO,    dest: 5'd2,  en: 8'h20, data: 32'h1234_5678, we: 1'b1, err: 1'b0};

    reset         = 1'b0;
    err_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sel       = '0;
    bus.in_dest   = '0;
    bus.src_en    = '0;
    bus.src_data  = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    reset = 1'b1;

    // Single push, 1-cycle latency, then drains.
    bus.out_ready = 1'b1;
    send(WB_ALU, 5'd8, 8'h7F, model(WB_ALU, 5'd8, 8'h7F));
    @(negedge clk);
    chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_occupancy", {30'd0, occupancy}, 32'd1);
    @(negedge clk);
    chk("t1_drained_occ", {30'd0, occupancy}, 32'd0);
    chk("t1_drained_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_data_kept", bus.out_data, 32'h0000_00AA);

    // Fill to two with the sink stalled; head must hold.
    step();
    bus.out_ready = 1'b0;
    send(WB_HI, 5'd9, 8'h7F, model(WB_HI, 5'd9, 8'h7F));
    send(WB_LO, 5'd10, 8'h7F, model(WB_LO, 5'd10, 8'h7F));
    @(negedge clk);
    chk("t2_occupancy", {30'd0, occupancy}, 32'd2);
    chk("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_head", bus.out_data, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    chk("t2_head_stall", bus.out_data, 32'hDEAD_BEEF);
    chk("t2_valid_stall", {31'd0, bus.out_valid}, 32'd1);
    step();
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_drained", {30'd0, occupancy}, 32'd0);

    // Simultaneous push and pop at occupancy 1.
    step();
    bus.out_ready = 1'b0;
    send(WB_LOAD, 5'd3, 8'h7F, model(WB_LOAD, 5'd3, 8'h7F));
    bus.out_ready = 1'b1;
    send(WB_SHIFT, 5'd31, 8'h7F, model(WB_SHIFT, 5'd31, 8'h7F));
    @(negedge clk);
    chk("t3_occupancy", {30'd0, occupancy}, 32'd1);
    chk("t3_new_head", bus.out_data, 32'h0F0F_0F0F);
    @(negedge clk);
    chk("t3_drained", {30'd0, occupancy}, 32'd0);

    // Vector table; err_clr held so err reflects only the latest accept.
    step();
    err_clr = 1'b1;
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.data = vt[i].data;
      e.dest = vt[i].dest;
      e.we   = vt[i].we;
      send(vt[i].sel, vt[i].dest, vt[i].en, e);
      @(negedge clk);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vt[i].err});
      step();
    end
    err_clr = 1'b0;
    repeat (2) @(negedge clk);

    // Sticky err, clear, and set-over-clear priority.
    step();
    send(WB_RSVD, 5'd4, 8'h7F, model(WB_RSVD, 5'd4, 8'h7F));
    @(negedge clk);
    chk("t4_err_set", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    step();
    err_clr = 1'b1;
    send(WB_RSVD, 5'd6, 8'h7F, model(WB_RSVD, 5'd6, 8'h7F));
    err_clr = 1'b0;
    @(negedge clk);
    chk("t4_set_priority", {31'd0, err}, 32'd1);
    repeat (2) @(negedge clk);

    // Reset with a full buffer discards everything.
    step();
    bus.out_ready = 1'b0;
    send(WB_RSVD, 5'd6, 8'h7F, model(WB_RSVD, 5'd6, 8'h7F));
    send(WB_HI, 5'd12, 8'h7F, model(WB_HI, 5'd12, 8'h7F));
    @(negedge clk);
    chk("t6_full", {30'd0, occupancy}, 32'd2);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_in_ready_rst", {31'd0, bus.in_ready}, 32'd0);
    step();
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t6_occupancy", {30'd0, occupancy}, 32'd0);
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_out_data", bus.out_data, 32'd0);
    chk("t6_out_dest", {27'd0, bus.out_dest}, 32'd0);
    chk("t6_out_we", {31'd0, bus.out_we}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    step();
    bus.out_ready = 1'b1;
    send(WB_SLT, 5'd5, 8'h7F, model(WB_SLT, 5'd5, 8'h7F));
    @(negedge clk);
    chk("t6_post_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t6_post_occ", {30'd0, occupancy}, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
- Parametrised successor to the combinational MemToReg write-back selector.
- Selects one of NUM_SRC write-back sources and captures the result, with the destination register, in a 2-entry skid-buffered pipeline stage.
- Handshake is valid/ready on both sides.
- Sits between the datapath result sources (ALU, load unit, shifter, SLT, HI, LO, constant 227) and the register-file write port.
- Adds write suppression for $zero, range checking of the select input, and occupancy reporting.

Parameters:
- WIDTH, 32, data width of every source and of out_data.
- NUM_SRC, 8, number of source inputs; legal range 2..16.
- SEL_W, $clog2(NUM_SRC), width of sel.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- src_data  in  NUM_SRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- src_en  in  NUM_SRC  per-source implemented mask; tie 0 for unused codes.
- sel  in  SEL_W  source select (MemToReg equivalent).
- in_dest  in  REG_AW  destination register number.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- out_data  out  WIDTH  selected value at the buffer head.
- out_dest  out  REG_AW  destination at the head.
- out_we  out  1  register-file write enable at the head.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file consumes the head.
- err  out  1  sticky illegal-select flag.
- err_clr  in  1  clears err.
- occupancy  out  2  number of buffered entries, 0..2.

Behaviour:
- Reset (reset==0 at a clock edge):
  - occupancy=0, out_valid=0, out_data=0, out_dest=0, out_we=0, err=0.
  - Buffer contents are discarded, including any entry in flight.
  - in_ready=0 during the reset cycle.
- Accept: push when in_valid && in_ready.
  - The value src_data[sel] is selected combinationally in the accepting cycle and registered.
  - Sources need not be held after acceptance.
- Pop: when out_valid && out_ready.
- Flow control:
  - in_ready = (occupancy<2).
  - out_valid = (occupancy>0).
- Latency: with the buffer empty, a request accepted at edge N appears on the outputs with out_valid=1 immediately after edge N (1 cycle).
- Ordering: strict FIFO; the second entry shifts to the head on pop.
- Simultaneous push and pop:
  - occupancy=1: occupancy stays 1; the new entry becomes the head after the edge.
  - occupancy=2: no push is possible (in_ready=0); the pop leaves occupancy=1.
- Illegal select: sel>=NUM_SRC, or src_en[sel]==0.
  - The entry is still accepted, with stored data=0 and we=0.
  - err is set on the accepting edge.
- $zero: in_dest==0 stores we=0; data is stored as selected.
- Legal select with in_dest!=0 stores we=1.
- err:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr clears err on the next edge.
- Outputs hold their value while out_valid && !out_ready; no change on a stall.
- When occupancy returns to 0, out_data, out_dest and out_we keep their last values; consumers qualify them with out_valid.
- No combinational path from in_valid to out_valid.
- in_ready depends only on registered occupancy, so there is no combinational path from out_ready to in_ready.

Decomposition:
- Shared package wb_pkg:
  - Select codes: WB_ALU=0, WB_LOAD=1, WB_SHIFT=2, WB_SLT=3, WB_HI=4, WB_LO=5, WB_C227=6, WB_RSVD=7.
  - Constant C227 = 32'd227.
  - Default REG_AW.
- Sub-module wb_skid_buffer:
  - Generic 2-entry valid/ready buffer over a {we, dest, data} payload.
  - The top level contains the select/check logic and err.

Test Plan:
1. Reset, then sel=0, ALU=32'h0000_00AA, in_dest=8, out_ready=1, single push -> next cycle out_valid=1, out_data=32'h0000_00AA, out_dest=8, out_we=1, occupancy=1; one cycle later occupancy=0.
2. out_ready=0; push sel=4 (HI=32'hDEAD_BEEF), then sel=5 (LO=32'h1234_5678) -> occupancy=2, in_ready=0, head=32'hDEAD_BEEF held stable; raise out_ready -> 32'h1234_5678 follows in order.
3. occupancy=1, push and pop in the same cycle -> occupancy stays 1, new data at the head, nothing lost or duplicated.
4. sel=7 with src_en[7]=0 -> entry emitted with out_data=0, out_we=0; err=1 and sticky; err_clr=1 -> err=0 the next cycle; err_clr together with a new illegal push -> err stays 1.
5. sel=6 (C227), in_dest=0 -> out_data=32'd227, out_we=0.
6. occupancy=2, assert reset=0 for one edge -> occupancy=0, out_valid=0, all outputs 0, err=0; first push after release emerges correctly with 1-cycle latency.
